// File: rtl/pin_irq_pkg.sv
// Shared types and default constants for the GPIO pin interrupt controller.
`include "Peripheral_Unit_defs.svh"

package pin_irq_pkg;

  localparam int PIN_IRQ_ID_W_DEF        = 5;
  localparam int PIN_IRQ_CLR_TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    CLEAR     = 2'd2,
    WAIT_DROP = 2'd3
  } pin_irq_state_e;

endpackage

// File: rtl/Peripheral_Unit_defs.svh
// Peripheral unit shared definitions: pin counts for the GPIO interrupt block.
`ifndef PERIPHERAL_UNIT_DEFS_SVH
`define PERIPHERAL_UNIT_DEFS_SVH

`define NUM_PINS 24

`endif

// File: rtl/pin_irq_prio_enc.sv
// Combinational priority encoder: finds the first set request at or above
// start_i, wrapping from NUM_PINS-1 back to 0.
module pin_irq_prio_enc #(
  parameter int NUM_PINS = 24,
  parameter int ID_W     = 5
) (
  input  logic [NUM_PINS-1:0] req_i,
  input  logic [ID_W-1:0]     start_i,
  output logic                vld_o,
  output logic [ID_W-1:0]     idx_o
);

  // Scan offsets from highest to lowest so the smallest offset is written last and wins.
  always_comb begin
    int j;
    vld_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      j = int'(start_i) + i;
      if (j >= NUM_PINS) j = j - NUM_PINS;
      if (req_i[j]) begin
        vld_o = 1'b1;
        idx_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/pin_irq_ctrl.sv
// GPIO pin interrupt controller: arbitrates latched pin flags, presents one
// source to the CPU, returns a one-hot clear pulse after acknowledge and waits
// for the flag to drop (sticky CLR_ERR on timeout).
// Optional feature: define PIN_IRQ_ROUND_ROBIN_EN for rotating priority;
// otherwise the lowest set index wins and no pointer register exists.
`include "Peripheral_Unit_defs.svh"

module pin_irq_ctrl
  import pin_irq_pkg::*;
#(
  parameter int NUM_PINS    = `NUM_PINS,
  parameter int ID_W        = PIN_IRQ_ID_W_DEF,
  parameter int CLR_TIMEOUT = PIN_IRQ_CLR_TIMEOUT_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_PINS-1:0] INTR,
  input  logic [NUM_PINS-1:0] IRQ_MASK,
  input  logic                IRQ_ACK,
  output logic                IRQ,
  output logic [ID_W-1:0]     IRQ_ID,
  output logic [NUM_PINS-1:0] IRQRES,
  output logic [NUM_PINS-1:0] PENDING,
  output logic                CLR_ERR
);

  localparam int CNT_W = $clog2(CLR_TIMEOUT + 1);

  function automatic logic [NUM_PINS-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_PINS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(NUM_PINS - 1)) ? '0 : idx + ID_W'(1);
  endfunction

  pin_irq_state_e      state_q;
  logic                irq_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_PINS-1:0] irqres_q;
  logic [NUM_PINS-1:0] pending_q;
  logic                clr_err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_PINS-1:0] req_vec;
  logic                sel_live;
  logic                win_vld;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     start_ptr;

  assign req_vec  = INTR & IRQ_MASK;
  assign sel_live = req_vec[id_q];

`ifdef PIN_IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;

  // Rotate the search start past the source that was just acknowledged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else if (state_q == REQ && IRQ_ACK) begin
      ptr_q <= wrap_inc(id_q);
    end
  end

  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
`endif

  pin_irq_prio_enc #(
    .NUM_PINS (NUM_PINS),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .req_i   (req_vec),
    .start_i (start_ptr),
    .vld_o   (win_vld),
    .idx_o   (win_idx)
  );

  // Request/acknowledge/clear handshake with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      id_q      <= '0;
      irqres_q  <= '0;
      pending_q <= '0;
      clr_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= req_vec;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            id_q    <= win_idx;
            irq_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // ACK beats a simultaneous withdrawal.
          if (IRQ_ACK) begin
            irq_q    <= 1'b0;
            irqres_q <= onehot(id_q);
            state_q  <= CLEAR;
          end else if (!sel_live) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          irqres_q <= '0;
          cnt_q    <= '0;
          state_q  <= WAIT_DROP;
        end
        WAIT_DROP: begin
          // Only the raw flag matters here; the mask is not consulted.
          if (!INTR[id_q]) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
            clr_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IRQ     = irq_q;
  assign IRQ_ID  = id_q;
  assign IRQRES  = irqres_q;
  assign PENDING = pending_q;
  assign CLR_ERR = clr_err_q;

endmodule

// File: tb/tb_pin_irq_ctrl.sv
// Bench for pin_irq_ctrl: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a transaction-level reference.
module tb_pin_irq_ctrl;

  localparam int N = 24;
  localparam int T = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  INTR = '0;
  logic [N-1:0]  IRQ_MASK = '1;
  logic          IRQ_ACK = 1'b0;
  logic          IRQ;
  logic [4:0]    IRQ_ID;
  logic [N-1:0]  IRQRES;
  logic [N-1:0]  PENDING;
  logic          CLR_ERR;

  int ntests = 0;
  int nfail  = 0;

  // Reference: what the CPU should see, tracked as "presenting", "clear pulse
  // due", "waiting for drop (with elapsed cycles)", sticky error, RR start.
  bit           m_present;
  int           m_cur;
  bit           m_pulse;
  bit           m_waiting;
  int           m_wait_cycles;
  bit           m_err;
  int           m_ptr;
  logic [N-1:0] m_pend;

  pin_irq_ctrl #(.NUM_PINS(N), .ID_W(5), .CLR_TIMEOUT(T)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .INTR     (INTR),
    .IRQ_MASK (IRQ_MASK),
    .IRQ_ACK  (IRQ_ACK),
    .IRQ      (IRQ),
    .IRQ_ID   (IRQ_ID),
    .IRQRES   (IRQRES),
    .PENDING  (PENDING),
    .CLR_ERR  (CLR_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_edge();
    logic [N-1:0] live;
    live = INTR & IRQ_MASK;
    if (RST) begin
      m_present = 0; m_cur = 0; m_pulse = 0; m_waiting = 0;
      m_wait_cycles = 0; m_err = 0; m_ptr = 0; m_pend = '0;
      return;
    end
    m_pend = live;
    if (m_pulse) begin
      m_pulse = 0;
      m_waiting = 1;
      m_wait_cycles = 0;
    end else if (m_waiting) begin
      if (!INTR[m_cur]) begin
        m_waiting = 0;
      end else begin
        m_wait_cycles++;
        if (m_wait_cycles >= T) begin
          m_err = 1;
          m_waiting = 0;
        end
      end
    end else if (m_present) begin
      if (IRQ_ACK) begin
        m_present = 0;
        m_pulse = 1;
`ifdef PIN_IRQ_ROUND_ROBIN_EN
        m_ptr = (m_cur + 1) % N;
`endif
      end else if (!live[m_cur]) begin
        m_present = 0;
      end
    end else if (live != '0) begin
      m_cur = pick(live, m_ptr);
      m_present = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] exp_res;
    exp_res = m_pulse ? (N'(1) << m_cur) : '0;
    chk("irq",     32'(IRQ),     32'(m_present));
    chk("irq_id",  32'(IRQ_ID),  32'(m_cur));
    chk("irqres",  32'(IRQRES),  32'(exp_res));
    chk("pending", 32'(PENDING), 32'(m_pend));
    chk("clr_err", 32'(CLR_ERR), 32'(m_err));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    RST = 1'b1; IRQ_ACK = 1'b0; INTR = '0; IRQ_MASK = '1;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    logic [N-1:0] flip;

    // Reset state
    do_reset();
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_id",  32'(IRQ_ID), 32'd0);
    chk("rst_err", 32'(CLR_ERR), 32'd0);

    // Lowest index wins, clear pulse, next source presented
    INTR = 24'h000090;
    step();
    chk("fp_irq", 32'(IRQ), 32'd1);
    chk("fp_id",  32'(IRQ_ID), 32'd4);
    IRQ_ACK = 1'b1;
    step();
    chk("fp_res", 32'(IRQRES), 32'h10);
    chk("fp_irq_clear", 32'(IRQ), 32'd0);
    IRQ_ACK = 1'b0;
    INTR = 24'h000080;
    step();
    chk("fp_res_once", 32'(IRQRES), 32'd0);
    step();
    step();
    chk("fp_next_irq", 32'(IRQ), 32'd1);
    chk("fp_next_id",  32'(IRQ_ID), 32'd7);

    // Masking
    do_reset();
    INTR = 24'h800000; IRQ_MASK = 24'h7FFFFF;
    step();
    step();
    chk("mask_irq", 32'(IRQ), 32'd0);
    chk("mask_pend", 32'(PENDING), 32'd0);
    IRQ_MASK = '1;
    step();
    chk("unmask_irq", 32'(IRQ), 32'd1);
    chk("unmask_id",  32'(IRQ_ID), 32'd23);

    // Withdrawal, then withdrawal racing an ACK
    do_reset();
    INTR = 24'h000004;
    step();
    INTR = '0;
    step();
    chk("wd_irq", 32'(IRQ), 32'd0);
    chk("wd_res", 32'(IRQRES), 32'd0);
    step();
    chk("wd_res2", 32'(IRQRES), 32'd0);
    INTR = 24'h000004;
    step();
    INTR = '0; IRQ_ACK = 1'b1;
    step();
    chk("race_res", 32'(IRQRES), 32'h4);
    IRQ_ACK = 1'b0;
    step();

    // Clear timeout
    do_reset();
    INTR = 24'h000020;
    step();
    IRQ_ACK = 1'b1;
    step();
    IRQ_ACK = 1'b0;
    for (int i = 0; i < 1 + T; i++) step();
    chk("to_err", 32'(CLR_ERR), 32'd1);
    step();
    chk("to_reirq", 32'(IRQ), 32'd1);
    chk("to_reid",  32'(IRQ_ID), 32'd5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("to_rst_err", 32'(CLR_ERR), 32'd0);

    // Reset during REQ aborts without a pulse
    INTR = 24'h000009;
    step();
    step();
    IRQ_ACK = 1'b1; RST = 1'b1;
    step();
    chk("mid_irq", 32'(IRQ), 32'd0);
    chk("mid_id",  32'(IRQ_ID), 32'd0);
    chk("mid_res", 32'(IRQRES), 32'd0);
    RST = 1'b0; IRQ_ACK = 1'b0; INTR = '0;
    step();

`ifdef PIN_IRQ_ROUND_ROBIN_EN
    // Rotation between two held sources
    do_reset();
    for (int r = 0; r < 4; r++) begin
      INTR = 24'h000003;
      step();
      chk("rr_id", 32'(IRQ_ID), 32'(r % 2));
      IRQ_ACK = 1'b1;
      step();
      IRQ_ACK = 1'b0;
      INTR = '0;
      step();
      step();
    end
`endif

    // Randomized traffic
    do_reset();
    INTR = '0;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      if ((c % 150) >= 20) begin
        flip = N'($urandom & $urandom & $urandom);
        INTR = INTR ^ flip;
      end
      if ($urandom_range(0, 49) == 0) IRQ_MASK = N'($urandom | $urandom);
      else if ($urandom_range(0, 49) == 0) IRQ_MASK = '1;
      IRQ_ACK = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pin_irq_ctrl.md
PIN_IRQ_CTRL -- requirements
Module: pin_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_PINS, default `NUM_PINS (24), the number of GPIO interrupt sources.
REQ-002 SHALL have parameter ID_W, default 5, the width of the source index (clog2(NUM_PINS)).
REQ-003 SHALL have parameter CLR_TIMEOUT, default 8, the maximum number of cycles spent waiting for a cleared flag to drop.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1, the reset; it is synchronous and active-high.
REQ-006 SHALL have port INTR, input, NUM_PINS, the latched per-pin interrupt flags from the pin mux GPIO cells.
REQ-007 SHALL have port IRQ_MASK, input, NUM_PINS, where 1 enables the source.
REQ-008 SHALL have port IRQ_ACK, input, 1, the CPU acknowledge; it is a level, sampled each cycle.
REQ-009 SHALL have port IRQ, output, 1, the interrupt request to the CPU.
REQ-010 SHALL have port IRQ_ID, output, ID_W, the index of the source being presented.
REQ-011 SHALL have port IRQRES, output, NUM_PINS, the one-hot clear pulse returned to the GPIO cells.
REQ-012 SHALL have port PENDING, output, NUM_PINS, which is registered INTR & IRQ_MASK for status readback.
REQ-013 SHALL have port CLR_ERR, output, 1, a sticky flag set on clear timeout.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, CLEAR and WAIT_DROP.
REQ-015 IDLE: when (INTR & IRQ_MASK) != 0, SHALL capture the winning index into IRQ_ID and go to REQ; IRQ SHALL be 1 on the cycle after INTR is sampled (1-cycle latency).
REQ-016 REQ: SHALL hold IRQ=1 with IRQ_ID stable; when IRQ_ACK=1, SHALL go to CLEAR.
REQ-017 REQ: if the selected source deasserts or becomes masked with IRQ_ACK=0, SHALL return to IDLE with no IRQRES pulse (withdrawn request).
REQ-018 REQ: if IRQ_ACK and withdrawal occur in the same cycle, SHALL treat the ACK as winning and go to CLEAR.
REQ-019 CLEAR: SHALL assert IRQ=0 and IRQRES[IRQ_ID]=1 for exactly one cycle, then go to WAIT_DROP; all other IRQRES bits SHALL be 0 at all times.
REQ-020 WAIT_DROP: SHALL hold IRQ=0 and go to IDLE once INTR[IRQ_ID]=0.
REQ-021 WAIT_DROP: after CLR_TIMEOUT cycles without the drop, SHALL set CLR_ERR=1 and go to IDLE.
REQ-022 Counter: the WAIT_DROP counter SHALL be cleared on every entry to WAIT_DROP.
REQ-023 CLR_ERR SHALL stay set until RST.
REQ-024 SHALL ignore IRQ_ACK in IDLE, CLEAR and WAIT_DROP.
REQ-025 Changes to IRQ_MASK SHALL affect arbitration only in IDLE and the withdrawal check in REQ.
REQ-026 Priority, without the round-robin feature: the lowest set index SHALL win.

Reset
REQ-027 On RST=1 at a clock edge, SHALL set state=IDLE, IRQ=0, IRQ_ID=0, IRQRES=0, PENDING=0, CLR_ERR=0, the timeout counter to 0 and the RR pointer to 0.
REQ-028 RST asserted mid-handshake SHALL abort the handshake with no IRQRES pulse.

Configuration
REQ-029 With macro PIN_IRQ_ROUND_ROBIN_EN defined, SHALL search from pointer PTR upward with wrap-around at NUM_PINS-1 to 0.
REQ-030 With PIN_IRQ_ROUND_ROBIN_EN defined, SHALL set PTR=(IRQ_ID+1) mod NUM_PINS on ACK.
REQ-031 Without PIN_IRQ_ROUND_ROBIN_EN, SHALL use fixed lowest-index priority (REQ-026) and SHALL contain no pointer register.

Structure
REQ-032 Shared package pin_irq_pkg SHALL hold the state enum (IDLE/REQ/CLEAR/WAIT_DROP) and the ID_W and CLR_TIMEOUT default constants; NUM_PINS SHALL come from Peripheral_Unit_defs.svh.
REQ-033 Sub-module pin_irq_prio_enc SHALL be purely combinational, take request vector plus start pointer, and output a valid flag and index.

Verification
REQ-034 Fixed priority: INTR=0x000090, MASK=all ones -> IRQ=1 next cycle, IRQ_ID=4; ACK -> IRQRES=0x000010 for one cycle; drop INTR[4] -> IRQ_ID=7 presented.
REQ-035 Masking: INTR=0x800000, MASK=0x7FFFFF -> IRQ stays 0 and PENDING=0; set MASK[23] -> IRQ=1 and IRQ_ID=23 one cycle later.
REQ-036 Withdrawal and simultaneity: INTR[2] drops in REQ with no ACK -> IDLE and IRQRES=0; repeat with ACK in the same cycle -> IRQRES=0x000004.
REQ-037 Timeout: ACK source 5 and hold INTR[5]=1 -> after 8 WAIT_DROP cycles CLR_ERR=1 and IRQ re-asserts for ID 5; RST -> CLR_ERR=0.
REQ-038 Round-robin (PIN_IRQ_ROUND_ROBIN_EN): INTR=0x000003 held, each ACK followed by re-raise -> IRQ_ID sequence 0,1,0,1; INTR=0x800001 with PTR=23 -> 23 then 0.
REQ-039 Reset mid-operation: RST asserted during REQ -> the next cycle shows IRQ=0, IRQ_ID=0, IRQRES=0.
